apb_master_bridge: RTL and testbench

- Single-outstanding request/response to APB master bridge.
- Converts a valid/ready request channel from the core-side interconnect into APB SETUP/ACCESS transfers.
- Drives the upstream (slv_*) side of the APB bus mux directly. Returns read data and error on a valid/ready response channel.
- Has a programmable PREADY timeout so that a hung peripheral cannot lock the bus.

---
 rtl/apb_master_bridge_if.sv | 47 ++++
 rtl/apb_master_bridge.sv | 132 +++++++++++++
 tb/tb_apb_master_bridge.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Bundle of the core-side request/response channels and the upstream APB
// signals seen by apb_master_bridge.
interface apb_master_bridge_if #(
  parameter int DWID = 8,
  parameter int AWID = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AWID-1:0] req_addr;
  logic [DWID-1:0] req_wdata;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [DWID-1:0] rsp_rdata;
  logic            rsp_err;
  logic            rsp_timeout;

  logic            m_psel;
  logic            m_penable;
  logic            m_pwrite;
  logic [AWID-1:0] m_paddr;
  logic [DWID-1:0] m_pwdata;
  logic            m_pready;
  logic            m_pslverr;
  logic [DWID-1:0] m_prdata;

  // Bridge view: accepts requests, produces responses, masters the APB bus.
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
    input  m_pready, m_pslverr, m_prdata
  );

  // Environment view: the core-side requester plus the APB peripheral side.
  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata,
    output m_pready, m_pslverr, m_prdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready to APB master bridge with a PREADY timeout
// that aborts a hung ACCESS phase and reports it as an error response.
module apb_master_bridge #(
  parameter int DWID    = 8,
  parameter int AWID    = 32,
  parameter int TIMEOUT = 256,
  parameter int CWID    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  apb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [CWID-1:0] TO_LAST = CWID'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  function automatic logic [CWID-1:0] sat_inc(input logic [CWID-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t          state, state_nxt;
  logic [CWID-1:0] cnt, cnt_nxt;
  logic            psel, psel_nxt;
  logic            penable, penable_nxt;
  logic            pwrite, pwrite_nxt;
  logic [AWID-1:0] paddr, paddr_nxt;
  logic [DWID-1:0] pwdata, pwdata_nxt;
  logic            rvalid, rvalid_nxt;
  logic [DWID-1:0] rdata, rdata_nxt;
  logic            rerr, rerr_nxt;
  logic            rto, rto_nxt;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    psel_nxt    = psel;
    penable_nxt = penable;
    pwrite_nxt  = pwrite;
    paddr_nxt   = paddr;
    pwdata_nxt  = pwdata;
    rvalid_nxt  = rvalid;
    rdata_nxt   = rdata;
    rerr_nxt    = rerr;
    rto_nxt     = rto;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          paddr_nxt  = bus.req_addr;
          pwdata_nxt = bus.req_wdata;
          pwrite_nxt = bus.req_write;
          psel_nxt   = 1'b1;
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        // A peripheral completing on the final allowed cycle still wins.
        if (bus.m_pready) begin
          rdata_nxt   = pwrite ? '0 : bus.m_prdata;
          rerr_nxt    = bus.m_pslverr;
          rto_nxt     = 1'b0;
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          rvalid_nxt  = 1'b1;
          state_nxt   = RESP;
        end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
          rdata_nxt   = '0;
          rerr_nxt    = 1'b1;
          rto_nxt     = 1'b1;
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          rvalid_nxt  = 1'b1;
          state_nxt   = RESP;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rvalid_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rerr    <= 1'b0;
      rto     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      psel    <= psel_nxt;
      penable <= penable_nxt;
      pwrite  <= pwrite_nxt;
      paddr   <= paddr_nxt;
      pwdata  <= pwdata_nxt;
      rvalid  <= rvalid_nxt;
      rdata   <= rdata_nxt;
      rerr    <= rerr_nxt;
      rto     <= rto_nxt;
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.m_psel      = psel;
  assign bus.m_penable   = penable;
  assign bus.m_pwrite    = pwrite;
  assign bus.m_paddr     = paddr;
  assign bus.m_pwdata    = pwdata;
  assign bus.rsp_valid   = rvalid;
  assign bus.rsp_rdata   = rdata;
  assign bus.rsp_err     = rerr;
  assign bus.rsp_timeout = rto;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge built with TIMEOUT = 4.
module tb_apb_master_bridge;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;

  apb_master_bridge_if #(.DWID(8), .AWID(32)) bus ();

  apb_master_bridge #(.DWID(8), .AWID(32), .TIMEOUT(4), .CWID(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic request(input logic wr, input logic [31:0] addr, input logic [7:0] wd);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstn          = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.m_pready  = 1'b0;
    bus.m_pslverr = 1'b0;
    bus.m_prdata  = '0;

    // Reset state
    #1;
    chk("rst_psel",      32'(bus.m_psel),      32'h0);
    chk("rst_penable",   32'(bus.m_penable),   32'h0);
    chk("rst_pwrite",    32'(bus.m_pwrite),    32'h0);
    chk("rst_paddr",     bus.m_paddr,          32'h0);
    chk("rst_pwdata",    32'(bus.m_pwdata),    32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid),   32'h0);
    chk("rst_rsp_err",   32'(bus.rsp_err),     32'h0);
    chk("rst_rsp_to",    32'(bus.rsp_timeout), 32'h0);
    chk("rst_rdata",     32'(bus.rsp_rdata),   32'h0);
    chk("rst_req_ready", 32'(bus.req_ready),   32'h1);
    step(); step();
    rstn = 1'b1;
    step();

    // Write, zero wait states
    request(1'b1, 32'h1004, 8'hA5);
    bus.m_pready = 1'b1;
    bus.m_prdata = 8'hFF;
    chk("wr_req_ready_T", 32'(bus.req_ready), 32'h1);
    step();                                     // T+1
    bus.req_valid = 1'b0;
    chk("wr_setup_psel",    32'(bus.m_psel),    32'h1);
    chk("wr_setup_penable", 32'(bus.m_penable), 32'h0);
    chk("wr_setup_ready",   32'(bus.req_ready), 32'h0);
    step();                                     // T+2
    chk("wr_acc_psel",    32'(bus.m_psel),    32'h1);
    chk("wr_acc_penable", 32'(bus.m_penable), 32'h1);
    chk("wr_acc_paddr",   bus.m_paddr,        32'h1004);
    chk("wr_acc_pwdata",  32'(bus.m_pwdata),  32'hA5);
    chk("wr_acc_pwrite",  32'(bus.m_pwrite),  32'h1);
    step();                                     // T+3
    chk("wr_rsp_valid", 32'(bus.rsp_valid),   32'h1);
    chk("wr_rsp_err",   32'(bus.rsp_err),     32'h0);
    chk("wr_rsp_to",    32'(bus.rsp_timeout), 32'h0);
    chk("wr_rsp_rdata", 32'(bus.rsp_rdata),   32'h0);
    chk("wr_rsp_psel",  32'(bus.m_psel),      32'h0);
    step();                                     // back in IDLE
    chk("wr_idle_valid", 32'(bus.rsp_valid), 32'h0);
    chk("wr_idle_ready", 32'(bus.req_ready), 32'h1);
    chk("wr_idle_paddr", bus.m_paddr,        32'h1004);

    // Read, 3 wait states; PREADY arrives on the last cycle before timeout
    bus.m_pready = 1'b0;
    bus.m_prdata = 8'h3C;
    request(1'b0, 32'h8010, 8'h00);
    step();                                     // T+1
    bus.req_valid = 1'b0;
    chk("rd_setup_psel", 32'(bus.m_psel), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();                                   // T+2..T+4 wait states
      chk("rd_wait_penable", 32'(bus.m_penable), 32'h1);
      chk("rd_wait_paddr",   bus.m_paddr,        32'h8010);
      chk("rd_wait_valid",   32'(bus.rsp_valid), 32'h0);
    end
    step();                                     // T+5
    bus.m_pready = 1'b1;
    chk("rd_t5_psel",  32'(bus.m_psel),      32'h1);
    chk("rd_t5_paddr", bus.m_paddr,          32'h8010);
    chk("rd_t5_valid", 32'(bus.rsp_valid),   32'h0);
    step();                                     // T+6
    bus.m_pready = 1'b0;
    chk("rd_rsp_valid", 32'(bus.rsp_valid),   32'h1);
    chk("rd_rsp_rdata", 32'(bus.rsp_rdata),   32'h3C);
    chk("rd_rsp_err",   32'(bus.rsp_err),     32'h0);
    chk("rd_rsp_to",    32'(bus.rsp_timeout), 32'h0);
    step();

    // Slave error
    bus.m_pready  = 1'b1;
    bus.m_pslverr = 1'b1;
    bus.m_prdata  = 8'h5A;
    request(1'b0, 32'h2000, 8'h00);
    step();
    bus.req_valid = 1'b0;
    step();
    chk("se_acc_paddr", bus.m_paddr, 32'h2000);
    step();
    chk("se_rsp_valid", 32'(bus.rsp_valid),   32'h1);
    chk("se_rsp_err",   32'(bus.rsp_err),     32'h1);
    chk("se_rsp_to",    32'(bus.rsp_timeout), 32'h0);
    chk("se_rsp_rdata", 32'(bus.rsp_rdata),   32'h5A);
    bus.m_pready  = 1'b0;
    bus.m_pslverr = 1'b0;
    step();

    // Timeout after 4 ACCESS cycles; a late PREADY is ignored
    bus.m_prdata  = 8'h99;
    bus.rsp_ready = 1'b0;
    request(1'b0, 32'h3000, 8'h00);
    step();                                     // T+1
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();                                   // T+2..T+5
      chk("to_acc_psel",  32'(bus.m_psel),    32'h1);
      chk("to_acc_valid", 32'(bus.rsp_valid), 32'h0);
    end
    step();                                     // T+6
    chk("to_psel",      32'(bus.m_psel),      32'h0);
    chk("to_penable",   32'(bus.m_penable),   32'h0);
    chk("to_rsp_valid", 32'(bus.rsp_valid),   32'h1);
    chk("to_rsp_err",   32'(bus.rsp_err),     32'h1);
    chk("to_rsp_to",    32'(bus.rsp_timeout), 32'h1);
    chk("to_rsp_rdata", 32'(bus.rsp_rdata),   32'h0);
    bus.m_pready = 1'b1;
    bus.m_prdata = 8'h77;
    step();
    chk("to_late_valid", 32'(bus.rsp_valid),   32'h1);
    chk("to_late_rdata", 32'(bus.rsp_rdata),   32'h0);
    chk("to_late_to",    32'(bus.rsp_timeout), 32'h1);
    chk("to_late_psel",  32'(bus.m_psel),      32'h0);
    bus.m_pready  = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    chk("to_idle_valid", 32'(bus.rsp_valid), 32'h0);
    chk("to_idle_ready", 32'(bus.req_ready), 32'h1);

    // Response backpressure with a second request waiting
    bus.m_pready  = 1'b1;
    bus.m_prdata  = 8'h66;
    bus.rsp_ready = 1'b0;
    request(1'b1, 32'h0040, 8'h11);
    step();                                     // T+1
    request(1'b0, 32'h0044, 8'h22);
    step();                                     // T+2
    for (int i = 0; i < 5; i++) begin
      step();                                   // T+3..T+7
      chk("bp_rsp_valid", 32'(bus.rsp_valid),   32'h1);
      chk("bp_req_ready", 32'(bus.req_ready),   32'h0);
      chk("bp_rsp_rdata", 32'(bus.rsp_rdata),   32'h0);
      chk("bp_rsp_err",   32'(bus.rsp_err),     32'h0);
      chk("bp_rsp_to",    32'(bus.rsp_timeout), 32'h0);
      chk("bp_psel",      32'(bus.m_psel),      32'h0);
    end
    bus.rsp_ready = 1'b1;
    step();                                     // T+8
    chk("b2b_req_ready", 32'(bus.req_ready), 32'h1);
    chk("b2b_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    step();                                     // T+9
    bus.req_valid = 1'b0;
    chk("b2b_setup_psel",    32'(bus.m_psel),    32'h1);
    chk("b2b_setup_penable", 32'(bus.m_penable), 32'h0);
    chk("b2b_setup_paddr",   bus.m_paddr,        32'h0044);
    chk("b2b_setup_pwrite",  32'(bus.m_pwrite),  32'h0);
    step();                                     // T+10
    chk("b2b_acc_penable", 32'(bus.m_penable), 32'h1);
    step();                                     // T+11
    chk("b2b_rsp_valid2", 32'(bus.rsp_valid), 32'h1);
    chk("b2b_rsp_rdata",  32'(bus.rsp_rdata), 32'h66);
    step();

    // Reset asserted mid-ACCESS
    bus.m_pready = 1'b0;
    request(1'b1, 32'h0050, 8'h33);
    step();
    bus.req_valid = 1'b0;
    step();
    chk("rm_acc_penable", 32'(bus.m_penable), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rm_psel",      32'(bus.m_psel),    32'h0);
    chk("rm_penable",   32'(bus.m_penable), 32'h0);
    chk("rm_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rm_paddr",     bus.m_paddr,        32'h0);
    step();
    rstn = 1'b1;
    step();
    chk("rm_req_ready", 32'(bus.req_ready), 32'h1);
    chk("rm_psel_after", 32'(bus.m_psel),   32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
